// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC sequencer: owns the PC, keeps one imem fetch in flight at a time,
// and holds the returned instruction for decode while applying redirects and traps.
module fetch_pc_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INSTR_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_vector,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] pc_current
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;

    logic                  redirect_evt;
    logic [ADDR_WIDTH-1:0] redirect_tgt;

    // A trap outranks a branch/jump redirect arriving in the same cycle.
    assign redirect_evt = trap_valid | redirect_valid;
    assign redirect_tgt = trap_valid ? trap_vector : redirect_pc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_evt) pc_d = redirect_tgt;
            end

            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    // The accepted fetch targets the old PC; its response must be dropped.
                    if (redirect_evt) begin
                        pc_d   = redirect_tgt;
                        kill_d = 1'b1;
                    end
                end else if (redirect_evt) begin
                    pc_d = redirect_tgt;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_evt) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_evt) pc_d = redirect_tgt;
                    end else begin
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = pc_q;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_evt) begin
                    pc_d   = redirect_tgt;
                    kill_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_evt) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(INSTR_BYTES);
                    state_d = S_REQ;
                end
            end

            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_VECTOR;
            kill_q      <= 1'b0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign pc_current     = pc_q;

endmodule
